// File: rtl/uart_bridge_pkg.sv
// rtl/uart_bridge_pkg.sv - shared types and helpers for the UART word serializer
// FSM encoding, byte counts per word, ASCII control codes and nibble-to-hex mapping.
package uart_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_GUARD = 2'd2
  } ser_state_t;

  localparam int BYTES_RAW = 4;
  localparam int BYTES_HEX = 10;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // Uppercase hex: 0-9 -> '0'..'9', A-F -> 'A'..'F'
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
    if (nib < 4'd10) return 8'h30 + {4'h0, nib};
    else             return 8'h37 + {4'h0, nib};
  endfunction

endpackage

// File: rtl/uart_word_fifo.sv
// rtl/uart_word_fifo.sv - synchronous word FIFO with registered full/empty
// Pointers carry one extra MSB so full and empty are distinguishable at equal indices.
module uart_word_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic [AW:0]      wr_ptr_nxt, rd_ptr_nxt;
  logic             push, pop;

  assign push       = wr_en & ~full;
  assign pop        = rd_en & ~empty;
  assign wr_ptr_nxt = wr_ptr + {{AW{1'b0}}, push};
  assign rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, pop};

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      empty  <= (wr_ptr_nxt == rd_ptr_nxt);
      full   <= (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign level   = wr_ptr - rd_ptr;

endmodule

// File: rtl/uart_tx_word_serializer.sv
// rtl/uart_tx_word_serializer.sv - buffers 32-bit words and feeds them bytewise to the UART TX
// UART_TX_SER_HEX_EN: send each word as 8 ASCII hex digits plus CR LF instead of 4 raw bytes.
module uart_tx_word_serializer
  import uart_bridge_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              i_word,
  input  logic                     i_word_valid,
  output logic                     o_word_ready,
  output logic [7:0]               o_tx_data,
  output logic                     o_tx_valid,
  input  logic                     i_tx_ready,
  output logic                     o_busy,
  output logic [$clog2(DEPTH):0]   o_level
);

`ifdef UART_TX_SER_HEX_EN
  localparam logic [3:0] LAST_IDX = 4'(BYTES_HEX - 1);
`else
  localparam logic [3:0] LAST_IDX = 4'(BYTES_RAW - 1);
`endif

  ser_state_t  state, state_nxt;
  logic [31:0] hold_q, hold_d;
  logic [3:0]  idx_q, idx_d;
  logic [31:0] fifo_head;
  logic        fifo_full, fifo_empty, fifo_pop;
  logic [7:0]  byte_sel;

  uart_word_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (i_word_valid),
    .wr_data (i_word),
    .rd_en   (fifo_pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (o_level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      hold_q <= '0;
      idx_q  <= '0;
    end else begin
      state  <= state_nxt;
      hold_q <= hold_d;
      idx_q  <= idx_d;
    end
  end

  // GUARD spends one idle cycle after every accepted byte so the
  // transmitter's late ready drop can never admit a second byte.
  always_comb begin
    state_nxt = state;
    hold_d    = hold_q;
    idx_d     = idx_q;
    fifo_pop  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          hold_d    = fifo_head;
          idx_d     = '0;
          state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        if (i_tx_ready) state_nxt = ST_GUARD;
      end
      ST_GUARD: begin
        if (idx_q == LAST_IDX) begin
          idx_d     = '0;
          state_nxt = ST_IDLE;
        end else begin
          idx_d     = idx_q + 4'd1;
          state_nxt = ST_SEND;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

`ifdef UART_TX_SER_HEX_EN
  always_comb begin
    byte_sel = 8'h00;
    if (idx_q < 4'd8)       byte_sel = nibble_to_ascii(hold_q[{3'd7 - idx_q[2:0], 2'b00} +: 4]);
    else if (idx_q == 4'd8) byte_sel = ASCII_CR;
    else                    byte_sel = ASCII_LF;
  end
`else
  logic [1:0] lane;
  assign lane     = LSB_FIRST ? idx_q[1:0] : (2'd3 - idx_q[1:0]);
  assign byte_sel = hold_q[{lane, 3'b000} +: 8];
`endif

  assign o_word_ready = ~fifo_full;
  assign o_tx_valid   = (state == ST_SEND);
  assign o_tx_data    = o_tx_valid ? byte_sel : 8'h00;
  assign o_busy       = ~fifo_empty | (state != ST_IDLE);

endmodule
